// File: rtl/calc_pkg.sv
// Shared calculator datapath definitions: sequencer states and default operand width.
package calc_pkg;

  localparam int unsigned CALC_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference and borrow of a single bit position
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_sub3.sv
// Bit-serial ripple-borrow subtractor: RESULT = A - B (two's complement, WIDTH+1 bits),
// one bit per clock through a single full_subtractor cell, start/busy/done handshake.
// Optional SERIAL_SUB3_SIGNMAG_EN adds registered NEG / MAG (sign and magnitude) outputs.
module serial_sub3 #(
  parameter int unsigned WIDTH = calc_pkg::CALC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH:0]   RESULT
`ifdef SERIAL_SUB3_SIGNMAG_EN
  ,
  output logic             NEG,
  output logic [WIDTH-1:0] MAG
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  calc_pkg::state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-2:0] diff_q, diff_d;
  logic             bor_q, bor_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   result_d;
  logic             busy_d;
  logic             done_d;
  logic             d_c;
  logic             bout_c;
  logic [WIDTH-1:0] dbits_c;
`ifdef SERIAL_SUB3_SIGNMAG_EN
  logic             neg_d;
  logic [WIDTH-1:0] mag_d;
`endif

  // Single subtractor cell, reused every SHIFT cycle on the operand LSBs
  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (bor_q),
    .d    (d_c),
    .bout (bout_c)
  );

  // Complete difference bits as they stand once the current bit is included
  always_comb begin
    dbits_c = {d_c, diff_q};
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    bor_d    = bor_q;
    cnt_d    = cnt_q;
    result_d = RESULT;
    busy_d   = 1'b0;
    done_d   = 1'b0;
`ifdef SERIAL_SUB3_SIGNMAG_EN
    neg_d    = NEG;
    mag_d    = MAG;
`endif
    case (state_q)
      calc_pkg::IDLE, calc_pkg::DONE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          diff_d  = '0;
          bor_d   = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = calc_pkg::SHIFT;
        end else begin
          state_d = calc_pkg::IDLE;
        end
      end
      calc_pkg::SHIFT: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        diff_d = dbits_c[WIDTH-1:1];
        bor_d  = bout_c;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          result_d = {bout_c, dbits_c};
          done_d   = 1'b1;
          state_d  = calc_pkg::DONE;
`ifdef SERIAL_SUB3_SIGNMAG_EN
          neg_d    = bout_c;
          mag_d    = bout_c ? WIDTH'(~dbits_c + WIDTH'(1)) : dbits_c;
`endif
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = calc_pkg::IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= calc_pkg::IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      bor_q   <= 1'b0;
      cnt_q   <= '0;
      RESULT  <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
`ifdef SERIAL_SUB3_SIGNMAG_EN
      NEG     <= 1'b0;
      MAG     <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      bor_q   <= bor_d;
      cnt_q   <= cnt_d;
      RESULT  <= result_d;
      BUSY    <= busy_d;
      DONE    <= done_d;
`ifdef SERIAL_SUB3_SIGNMAG_EN
      NEG     <= neg_d;
      MAG     <= mag_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_sub3.sv
// Randomized self-checking bench for serial_sub3 against an arithmetic reference model.
// Define SERIAL_SUB3_SIGNMAG_EN for both files to also check NEG / MAG.
module tb_serial_sub3;

  localparam int unsigned W = 3;

  logic         clk;
  logic         rst_n;
  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BUSY;
  logic         DONE;
  logic [W:0]   RESULT;
`ifdef SERIAL_SUB3_SIGNMAG_EN
  logic         NEG;
  logic [W-1:0] MAG;
`endif

  int checks = 0;
  int errors = 0;
  logic [W:0] prev_res = '0;

  serial_sub3 #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .START  (START),
    .A      (A),
    .B      (B),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .RESULT (RESULT)
`ifdef SERIAL_SUB3_SIGNMAG_EN
    ,
    .NEG    (NEG),
    .MAG    (MAG)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if observed differs from expected
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: signed difference reduced modulo 2^(W+1)
  function automatic logic [W:0] ref_result(input int a, input int b);
    int diff;
    diff = a - b;
    return (W + 1)'(diff);
  endfunction

  // Present an operation so that the next rising edge accepts it
  task automatic start_op(input int a, input int b);
    @(negedge clk);
    A     = W'(a);
    B     = W'(b);
    START = 1'b1;
  endtask

  // Follow an accepted operation through BUSY and DONE; optionally chain the next one
  task automatic finish_op(input int a, input int b, input bit inject,
                           input bit hold, input int na, input int nb);
    logic [W:0] exp;
    exp = ref_result(a, b);
    for (int i = 0; i < int'(W); i++) begin
      @(negedge clk);
      START = inject ? 1'($urandom_range(0, 1)) : 1'b0;
      if (inject) begin
        A = W'($urandom_range(0, 7));
        B = W'($urandom_range(0, 7));
      end
      check("busy_high", 32'(BUSY), 32'd1);
      check("done_low_in_shift", 32'(DONE), 32'd0);
      check("result_held", 32'(RESULT), 32'(prev_res));
    end
    @(negedge clk);
    check("done_pulse", 32'(DONE), 32'd1);
    check("busy_low_in_done", 32'(BUSY), 32'd0);
    check("result", 32'(RESULT), 32'(exp));
`ifdef SERIAL_SUB3_SIGNMAG_EN
    check("neg", 32'(NEG), (a < b) ? 32'd1 : 32'd0);
    check("mag", 32'(MAG), (a < b) ? 32'(b - a) : 32'(a - b));
`endif
    prev_res = exp;
    if (hold) begin
      A     = W'(na);
      B     = W'(nb);
      START = 1'b1;
    end else begin
      START = 1'b0;
      A     = W'($urandom_range(0, 7));
      B     = W'($urandom_range(0, 7));
      @(negedge clk);
      check("done_single_cycle", 32'(DONE), 32'd0);
      check("idle_busy_low", 32'(BUSY), 32'd0);
      check("result_kept", 32'(RESULT), 32'(exp));
    end
  endtask

  initial begin
    int ta [5] = '{5, 3, 0, 7, 6};
    int tb [5] = '{3, 5, 7, 0, 6};
    int ra;
    int rb;
    rst_n = 1'b0;
    START = 1'b0;
    A     = '0;
    B     = '0;
    #12;
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_result", 32'(RESULT), 32'd0);
`ifdef SERIAL_SUB3_SIGNMAG_EN
    check("rst_neg", 32'(NEG), 32'd0);
    check("rst_mag", 32'(MAG), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed operand pairs, including the extremes and equal operands
    for (int i = 0; i < 5; i++) begin
      start_op(ta[i], tb[i]);
      finish_op(ta[i], tb[i], 1'b0, 1'b0, 0, 0);
    end

    // START pulses with other operands while shifting are ignored
    start_op(6, 1);
    finish_op(6, 1, 1'b1, 1'b0, 0, 0);

    // Back-to-back: START held across DONE with new operands
    start_op(7, 2);
    finish_op(7, 2, 1'b0, 1'b1, 2, 4);
    finish_op(2, 4, 1'b0, 1'b0, 0, 0);

    // Random operations, random interference during SHIFT, random chaining
    ra = $urandom_range(0, 7);
    rb = $urandom_range(0, 7);
    start_op(ra, rb);
    for (int i = 0; i < 30; i++) begin
      int na;
      int nb;
      bit hold;
      na   = $urandom_range(0, 7);
      nb   = $urandom_range(0, 7);
      hold = (i != 29) && 1'($urandom_range(0, 1));
      finish_op(ra, rb, 1'($urandom_range(0, 1)), hold, na, nb);
      if (!hold && i != 29) start_op(na, nb);
      ra = na;
      rb = nb;
    end

    // Reset during the second SHIFT cycle aborts the operation
    start_op(4, 1);
    @(negedge clk);
    START = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_done", 32'(DONE), 32'd0);
    check("abort_result", 32'(RESULT), 32'd0);
    prev_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_done_after_abort", 32'(DONE), 32'd0);
      check("no_busy_after_abort", 32'(BUSY), 32'd0);
    end
    start_op(1, 1);
    finish_op(1, 1, 1'b0, 1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_sub3.md
Name: serial_sub3

Overview:
- Bit-serial ripple-borrow subtractor for the calculator datapath; the inverse operation of the 3-bit ripple adder.
- Computes A − B one bit per clock using a single full-subtractor cell.
- Returns a 4-bit two's-complement difference under a start/busy/done handshake.
- Sits beside the adder; the operation-select mux reads RESULT when DONE pulses.

Parameters:
- WIDTH, 3: operand width in bits. RESULT is WIDTH+1 bits. The bit counter is $clog2(WIDTH+1) bits.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- START  input  1  request; sampled only in IDLE or DONE state
- A  input  WIDTH  minuend; captured on the accepted START
- B  input  WIDTH  subtrahend; captured on the accepted START
- BUSY  output  1  high while bits are being computed
- DONE  output  1  one-cycle pulse when RESULT becomes valid
- RESULT  output  WIDTH+1  two's-complement A − B, held until the next accepted START

Behaviour:
- Reset (async assert, removal synchronous to clk):
  - state=IDLE; BUSY=0; DONE=0; RESULT=0.
  - Internal shift registers, borrow flop and bit counter are cleared.
- States:
  - IDLE: START=1 → latch A, B; borrow=0; cnt=0; go to SHIFT.
  - SHIFT: each cycle, full_subtractor(a_sh[0], b_sh[0], borrow) produces d and bout.
    - d shifts into the MSB of the difference register; a_sh and b_sh shift right.
    - borrow ← bout; cnt increments.
    - When cnt==WIDTH−1, go to DONE on the same edge that stores the last bit.
  - DONE: RESULT = {final borrow, difference bits}. DONE=1 for exactly this one cycle.
    - START=1 here → accept a new operation and go to SHIFT (back-to-back).
    - Otherwise go to IDLE.
- Latency: START sampled at edge k → BUSY high for cycles k+1..k+WIDTH → DONE high in cycle k+WIDTH+1. For WIDTH=3, DONE is high 4 cycles after START.
- Arithmetic:
  - Cell: d = a^b^bin; bout = (~a&b) | (~(a^b)&bin).
  - Final borrow is the sign bit, so RESULT equals (A − B) mod 2^(WIDTH+1). Range is −(2^WIDTH−1)..+(2^WIDTH−1); no overflow is possible.
- Boundaries:
  - START while in SHIFT: ignored; no queueing.
  - A, B changing during SHIFT: no effect, because operands are captured at accept.
  - RESULT does not change until DONE of the next operation; intermediate bits stay internal.
  - rst_n low mid-operation: immediate abort; all outputs take their reset values; no DONE is produced.
  - A==B: RESULT=0, final borrow=0.

Optional Feature:
- Macro: SERIAL_SUB3_SIGNMAG_EN
- Defined:
  - Adds outputs NEG (1 bit) and MAG (WIDTH bits), registered and updated in the same cycle as RESULT.
  - NEG = final borrow. MAG = |A − B|, computed combinationally from the difference bits as two's-complement negation when NEG=1.
  - Both reset to 0.
- Undefined: NEG and MAG ports do not exist. Area and behaviour are otherwise identical.

Decomposition:
- Shared package calc_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - Constant CALC_W=3, used as the default for WIDTH.
- One natural sub-module: full_subtractor (a, b, bin → d, bout), the dual of the existing full_adder cell. It is instantiated once and reused every cycle.

Test Plan:
- Reset then A=5, B=3, START 1 cycle → BUSY high 3 cycles, DONE pulse at cycle 4, RESULT=4'b0010; NEG=0, MAG=2 if enabled.
- A=3, B=5 → RESULT=4'b1110; NEG=1, MAG=2 if enabled.
- A=0, B=7 → 4'b1001. A=7, B=0 → 4'b0111. A=6, B=6 → 4'b0000.
- START pulses during SHIFT with different operands → ignored; the original result is returned; DONE pulses once.
- START held high across DONE with new A=2, B=4 → second operation accepted in the DONE cycle; RESULT=4'b1110 four cycles later; first RESULT held until then.
- rst_n asserted in the 2nd SHIFT cycle → BUSY, DONE, RESULT go to 0 immediately; no DONE after release; the next operation (1−1) gives 0.
